// File: rtl/bus_arbiter_rr4_if.sv
// Bundle of request, data and grant signals shared by four requesters and the arbiter.
// Latency: none, this is wiring only.
// Backpressure: a requester holds req high until its grant shows up.
interface bus_arbiter_rr4_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic [WIDTH-1:0] bus_value;
  logic             bus_valid;

  // Requester side: drives requests and data, observes the grant and the bus.
  modport master (
    output req, data0, data1, data2, data3,
    input  grant, sel, bus_value, bus_valid
  );

  // Arbiter side: samples requests and data, drives the grant and the bus.
  modport slave (
    input  req, data0, data1, data2, data3,
    output grant, sel, bus_value, bus_valid
  );
endinterface

// File: rtl/bus_arbiter_rr4.sv
// Round-robin arbiter for four requesters on one shared bus, with a bounded tenure.
// Latency: a request sampled at one edge is granted at the next edge; bus_value is combinational from the registered sel.
// Backpressure: requesters hold req until granted; a tenure ends when req drops or MAX_HOLD cycles are used.
module bus_arbiter_rr4 #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst_n,
  bus_arbiter_rr4_if.slave bus
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t           state;
  logic [3:0]       grant_q;
  logic [1:0]       sel_q;
  logic [1:0]       ptr;
  logic [3:0]       cnt;

  logic             any_req;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             release_now;
  logic [WIDTH-1:0] mux_lo;
  logic [WIDTH-1:0] mux_hi;
  logic [WIDTH-1:0] mux_out;

  // Pick the first requester at or after ptr (ascending, wrapping). Scanning from the
  // farthest offset down lets the nearest set bit overwrite the earlier candidates.
  always_comb begin
    any_req = |bus.req;
    win     = ptr;
    idx     = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.req[idx]) win = idx;
    end
  end

  // The tenure ends when nobody owns the bus, when the holder drops req, or when the hold limit is used up.
  always_comb begin
    release_now = (state == IDLE) || !bus.req[sel_q] || (cnt == HOLD_LIM);
  end

  // Arbitration FSM. A release re-arbitrates at the same edge, so a switch leaves no idle
  // cycle. ptr already points past the old holder, so that holder is re-granted only
  // when it is the sole requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      ptr     <= 2'd0;
      cnt     <= 4'd0;
    end else if (release_now) begin
      if (any_req) begin
        state   <= OWN;
        grant_q <= 4'b0001 << win;
        sel_q   <= win;
        cnt     <= 4'd1;
        ptr     <= win + 2'd1;
      end else begin
        state   <= IDLE;
        grant_q <= 4'b0000;
        sel_q   <= 2'd0;
        cnt     <= 4'd0;
      end
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  // Two levels of 2:1 selects driven by sel, then gated so the bus reads zero when idle.
  always_comb begin
    mux_lo  = sel_q[0] ? bus.data1 : bus.data0;
    mux_hi  = sel_q[0] ? bus.data3 : bus.data2;
    mux_out = sel_q[1] ? mux_hi : mux_lo;
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.bus_valid = |grant_q;
  assign bus.bus_value = mux_out & {WIDTH{|grant_q}};

endmodule

// File: doc/bus_arbiter_rr4.md
Name: bus_arbiter_rr4

Overview:
- Round-robin arbiter sharing one 8-bit datapath bus between four requesters.
- Registers a one-hot grant and a 2-bit select.
- Steers the granted requester's data onto the shared bus through a 4:1 AND-OR select built from 2:1 select stages.
- Bounds bus tenure with a hold limit so that no requester starves the others.

Parameters:
- WIDTH, 8, data width of each requester and of the bus.
- MAX_HOLD, 4, maximum consecutive granted cycles per tenure (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request, one bit per requester; level-sensitive, held while the requester wants the bus.
- data0  input  WIDTH  requester 0 data.
- data1  input  WIDTH  requester 1 data.
- data2  input  WIDTH  requester 2 data.
- data3  input  WIDTH  requester 3 data.
- grant  output  4  registered one-hot grant, or 0 when idle.
- sel  output  2  registered index of the granted requester.
- bus_value  output  WIDTH  shared bus; data of the granted requester, 0 when idle.
- bus_valid  output  1  high when any grant is active.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - rst_n low forces immediately: grant=0, sel=0, bus_valid=0, bus_value=0, priority pointer ptr=0, hold counter cnt=0, state IDLE.
  - Reset mid-tenure drops the grant in the same instant, without waiting for a clock edge.
- State machine: IDLE and OWN.
  - IDLE, req==0: stay IDLE.
  - IDLE, req!=0: go to OWN at the next edge, grant winner, cnt=1.
  - OWN, holder's req still high and cnt<MAX_HOLD: stay, cnt++.
  - OWN, holder's req low: release, or forced release when cnt==MAX_HOLD.
  - On release, if any req is high (including the holder's): re-arbitrate at the same edge, grant the new winner with no bubble, cnt=1.
  - On release, if no req is high: go to IDLE, grant=0.
- Winner selection: scan req starting at index ptr, ascending mod 4; the first set bit wins.
  - ptr updates to (winner+1) mod 4 at every grant edge.
  - After release by requester k, the others get priority; k is re-granted only if it is the sole requester.
- Latency: a request seen at edge N is granted at edge N+1 if the bus is free. It is never granted in the same cycle it is raised.
- Output derivation:
  - grant and sel are registered and always consistent: grant == 1<<sel when bus_valid is high.
  - bus_valid = |grant.
  - bus_value is combinational from the registered sel and the current dataN: dataN when grant[N], else all zeros.
  - Implement bus_value as a two-level tree of 2:1 selects, followed by an AND with bus_valid.
- Worst-case wait: with all four requesting, any requester waits at most 3*MAX_HOLD cycles.
- Counter: cnt is 4 bits and never exceeds MAX_HOLD; no wrap.
- Requests appearing or dropping in the same cycle as a release are sampled at that release edge.
- A req dropping for a non-holder while waiting simply removes it from arbitration.
- Grant never has more than one bit set.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> grant=0, bus_valid=0, bus_value=8'h00. Release rst_n at edge 0 -> grant=4'b0001 at edge 1, bus_value=data0.
- Single requester: req=4'b0100, data2=8'hA5 -> edge+1: grant=4'b0100, sel=2, bus_value=8'hA5. Drop req -> next edge: grant=0, bus_value=8'h00.
- Hold limit, sole requester: req=4'b0010 held for 10 cycles, MAX_HOLD=4 -> grant=4'b0010 continuously, with no bubble. cnt follows 1,2,3,4,1,2,... and bus_valid stays 1.
- Round robin, all requesting: req=4'b1111 constant from reset -> grants go 0,1,2,3,0, each for exactly 4 cycles. Switches have no idle cycle, and grant is one-hot in every cycle.
- Early release with contention: req0 granted, req2 and req3 pending; req0 drops after 2 cycles -> next edge grant=4'b0100. With req2 held, req3 is granted after 4 more cycles.
- Async reset mid-tenure: grant=4'b1000, bus_value=data3=8'h3C; pulse rst_n low between edges -> grant and bus_value go to 0 before the next edge. After release with req=4'b1000, grant is restored one edge later with ptr restarted at 0.
